// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: FSM state, default widths, loop-stack entry.
package gpu_pkg;

  localparam int unsigned PC_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD_BR = 2'd1,
    ST_SQUASH  = 2'd2
  } fe_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  body_pc;
    logic [CNT_W_DEF-1:0] count;
  } loop_entry_t;

endpackage

// File: rtl/loop_stack.sv
// Hardware loop LIFO.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_push      : push i_entry (ignored when full)
//   i_pop       : drop top entry (ignored when empty)
//   i_dec       : decrement top entry count (ignored when empty)
//   o_top       : current top entry (undefined when empty)
//   o_depth     : live entries; o_full / o_empty status
module loop_stack
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_dec,
  input  loop_entry_t                i_entry,
  output loop_entry_t                o_top,
  output logic [$clog2(DEPTH):0]     o_depth,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;
  localparam int unsigned CW      = CNT_W_DEF;

  loop_entry_t        r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic [PTR_W-1:0]   w_top_idx;
  logic [PTR_W-1:0]   w_wr_idx;

  assign w_top_idx = PTR_W'(r_depth - DEPTH_W'(1));
  assign w_wr_idx  = PTR_W'(r_depth);
  assign o_top     = r_mem[w_top_idx];
  assign o_depth   = r_depth;
  assign o_full    = (r_depth == DEPTH_W'(DEPTH));
  assign o_empty   = (r_depth == '0);

  // Occupancy pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_depth <= '0;
    end else if (i_push && !o_full) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (i_pop && !o_empty) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  // Entry storage; contents above the pointer are don't-care, so no reset
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_entry;
    end else if (i_dec && !o_empty) begin
      r_mem[w_top_idx].count <= r_mem[w_top_idx].count - CW'(1);
    end
  end

endmodule

// File: rtl/fe_ctrl.sv
// Fetch-stage sequencer: branch redirect hold/squash and LOOP/ENDLOOP control.
//   CLOCK_50, reset       : clock, synchronous active-high reset
//   hz_stall              : hazard freeze request (passed through as Stall)
//   br_valid/br_target    : taken branch resolved in EX
//   lp_push/lp_body_pc/lp_count : LOOP issued by decode
//   lp_end                : ENDLOOP issued by decode
//   Stall, Loop, PC_in    : fetch controls (Loop/PC_in/flush_id combinational)
//   flush_id              : squash decode-stage instruction
//   lp_depth, lp_err      : loop stack occupancy, sticky stack error
module fe_ctrl
  import gpu_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned LOOP_DEPTH = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        hz_stall,
  input  logic                        br_valid,
  input  logic [PC_W-1:0]             br_target,
  input  logic                        lp_push,
  input  logic [PC_W-1:0]             lp_body_pc,
  input  logic [CNT_W-1:0]            lp_count,
  input  logic                        lp_end,
  output logic                        Stall,
  output logic                        Loop,
  output logic [PC_W-1:0]             PC_in,
  output logic                        flush_id,
  output logic [$clog2(LOOP_DEPTH):0] lp_depth,
  output logic                        lp_err
);

  fe_state_e       r_state, w_state_nxt;
  logic [PC_W-1:0] r_br_target, w_br_target_nxt;
  logic            r_lp_err, w_lp_err_nxt;
  logic            w_push, w_pop, w_dec;
  logic            w_full, w_empty;
  loop_entry_t     w_top, w_push_entry;

  assign Stall  = hz_stall;
  assign lp_err = r_lp_err;

  // A zero iteration count still executes the body once
  assign w_push_entry.body_pc = lp_body_pc;
  assign w_push_entry.count   = (lp_count == '0) ? CNT_W'(1) : lp_count;

  loop_stack #(
    .DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dec   (w_dec),
    .i_entry (w_push_entry),
    .o_top   (w_top),
    .o_depth (lp_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state, redirect mux and stack commands
  always_comb begin
    w_state_nxt     = r_state;
    w_br_target_nxt = r_br_target;
    w_lp_err_nxt    = r_lp_err;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_dec           = 1'b0;
    Loop            = 1'b0;
    PC_in           = '0;
    flush_id        = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (br_valid) begin
          // Decode holds a wrong-path instruction either way
          flush_id = 1'b1;
          if (hz_stall) begin
            w_br_target_nxt = br_target;
            w_state_nxt     = ST_HOLD_BR;
          end else begin
            Loop        = 1'b1;
            PC_in       = br_target;
            w_state_nxt = ST_SQUASH;
          end
        end else if (!hz_stall) begin
          if (lp_end) begin
            if (lp_push || w_empty) begin
              w_lp_err_nxt = 1'b1;
            end
            if (!w_empty) begin
              if (w_top.count > CNT_W'(1)) begin
                w_dec       = 1'b1;
                Loop        = 1'b1;
                PC_in       = w_top.body_pc;
                w_state_nxt = ST_SQUASH;
              end else begin
                w_pop = 1'b1;
              end
            end
          end else if (lp_push) begin
            if (w_full) begin
              w_lp_err_nxt = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end
        end
      end
      ST_HOLD_BR: begin
        flush_id = 1'b1;
        if (!hz_stall) begin
          Loop        = 1'b1;
          PC_in       = r_br_target;
          w_state_nxt = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        flush_id = 1'b1;
        if (!hz_stall) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // Nothing leaves the block while reset discards pending work
    if (reset) begin
      Loop     = 1'b0;
      PC_in    = '0;
      flush_id = 1'b0;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_dec    = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_br_target <= '0;
      r_lp_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_br_target <= w_br_target_nxt;
      r_lp_err    <= w_lp_err_nxt;
    end
  end

endmodule

// File: tb/tb_fe_ctrl.sv
module tb_fe_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        hz_stall;
  logic        br_valid;
  logic [15:0] br_target;
  logic        lp_push;
  logic [15:0] lp_body_pc;
  logic [7:0]  lp_count;
  logic        lp_end;
  logic        Stall;
  logic        Loop;
  logic [15:0] PC_in;
  logic        flush_id;
  logic [2:0]  lp_depth;
  logic        lp_err;

  int n_checks = 0;
  int n_pass   = 0;

  fe_ctrl #(.PC_W(16), .CNT_W(8), .LOOP_DEPTH(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .hz_stall   (hz_stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .lp_push    (lp_push),
    .lp_body_pc (lp_body_pc),
    .lp_count   (lp_count),
    .lp_end     (lp_end),
    .Stall      (Stall),
    .Loop       (Loop),
    .PC_in      (PC_in),
    .flush_id   (flush_id),
    .lp_depth   (lp_depth),
    .lp_err     (lp_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int pc; int cnt; } ent_t;
  ent_t q[$];
  bit   m_err;
  bit   m_owed;       // taken branch waiting for the stall to clear
  int   m_owed_tgt;
  bit   m_squash;     // one more decode slot must be killed

  always @(negedge CLOCK_50) begin
    int  e_loop, e_pc, e_flush;
    bit  n_owed, n_squash;
    ent_t e;
    if (reset) begin
      q.delete();
      m_err = 0; m_owed = 0; m_owed_tgt = 0; m_squash = 0;
    end else begin
      e_loop = 0; e_pc = 0; e_flush = 0;
      n_owed = m_owed; n_squash = m_squash;
      // registered outputs reflect the model before this cycle's update
      chk("lp_depth", int'(lp_depth), q.size());
      chk("lp_err", int'(lp_err), int'(m_err));
      if (m_owed) begin
        e_flush = 1;
        if (!hz_stall) begin
          e_loop = 1; e_pc = m_owed_tgt; n_owed = 0; n_squash = 1;
        end
      end else if (m_squash) begin
        e_flush = 1;
        if (!hz_stall) n_squash = 0;
      end else if (br_valid) begin
        e_flush = 1;
        if (hz_stall) begin
          n_owed = 1; m_owed_tgt = int'(br_target);
        end else begin
          e_loop = 1; e_pc = int'(br_target); n_squash = 1;
        end
      end else if (!hz_stall) begin
        if (lp_end) begin
          if (lp_push || q.size() == 0) m_err = 1;
          if (q.size() != 0) begin
            if (q[q.size()-1].cnt > 1) begin
              q[q.size()-1].cnt = q[q.size()-1].cnt - 1;
              e_loop = 1; e_pc = q[q.size()-1].pc; n_squash = 1;
            end else begin
              void'(q.pop_back());
            end
          end
        end else if (lp_push) begin
          if (q.size() == 4) m_err = 1;
          else begin
            e.pc  = int'(lp_body_pc);
            e.cnt = (lp_count == 0) ? 1 : int'(lp_count);
            q.push_back(e);
          end
        end
      end
      chk("Stall", int'(Stall), int'(hz_stall));
      chk("Loop", int'(Loop), e_loop);
      chk("PC_in", int'(PC_in), e_pc);
      chk("flush_id", int'(flush_id), e_flush);
      if (Loop && Stall) chk("loop_while_stall", 1, 0);
      m_owed = n_owed; m_squash = n_squash;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic hz, input logic br, input logic [15:0] tgt,
                     input logic ps, input logic [15:0] bpc, input logic [7:0] cnt,
                     input logic en);
    @(posedge CLOCK_50); #1;
    hz_stall = hz; br_valid = br; br_target = tgt;
    lp_push = ps; lp_body_pc = bpc; lp_count = cnt; lp_end = en;
    @(negedge CLOCK_50);
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 16'h0, 8'h0, 0);
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    reset = 1;
    hz_stall = 0; br_valid = 0; br_target = 0;
    lp_push = 0; lp_body_pc = 0; lp_count = 0; lp_end = 0;
    @(posedge CLOCK_50); #1;
    reset = 0;
    @(negedge CLOCK_50);
  endtask

  initial begin
    reset = 1;
    hz_stall = 0; br_valid = 0; br_target = 0;
    lp_push = 0; lp_body_pc = 0; lp_count = 0; lp_end = 0;
    do_reset();

    // reset state, idle
    repeat (5) idle();
    chk("rst_Stall", int'(Stall), 0);
    chk("rst_Loop", int'(Loop), 0);
    chk("rst_PC_in", int'(PC_in), 0);
    chk("rst_flush", int'(flush_id), 0);
    chk("rst_depth", int'(lp_depth), 0);
    chk("rst_err", int'(lp_err), 0);

    // unstalled branch
    cyc(0, 1, 16'h0020, 0, 0, 0, 0);
    chk("br_Loop", int'(Loop), 1);
    chk("br_PC_in", int'(PC_in), 16'h0020);
    chk("br_flush0", int'(flush_id), 1);
    idle();
    chk("br_flush1", int'(flush_id), 1);
    chk("br_Loop1", int'(Loop), 0);
    idle();
    chk("br_flush2", int'(flush_id), 0);

    // stalled branch held; a second branch during the hold is ignored
    cyc(1, 1, 16'h0011, 0, 0, 0, 0);
    chk("hold_Loop0", int'(Loop), 0);
    chk("hold_flush0", int'(flush_id), 1);
    cyc(1, 1, 16'h0099, 0, 0, 0, 0);
    chk("hold_flush1", int'(flush_id), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("hold_Loop2", int'(Loop), 0);
    idle();
    chk("hold_Loop", int'(Loop), 1);
    chk("hold_PC_in", int'(PC_in), 16'h0011);
    idle();
    chk("hold_sq_flush", int'(flush_id), 1);
    idle();
    chk("hold_done", int'(flush_id), 0);

    // loop of three iterations
    cyc(0, 0, 0, 1, 16'h0005, 8'd3, 0);
    chk("lp_push_Loop", int'(Loop), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lp_depth1", int'(lp_depth), 1);
    chk("lp_end1_Loop", int'(Loop), 1);
    chk("lp_end1_PC", int'(PC_in), 16'h0005);
    chk("lp_end1_noflush", int'(flush_id), 0);
    idle();
    chk("lp_sq1", int'(flush_id), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lp_end2_Loop", int'(Loop), 1);
    chk("lp_end2_PC", int'(PC_in), 16'h0005);
    idle();
    chk("lp_sq2", int'(flush_id), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lp_end3_Loop", int'(Loop), 0);
    chk("lp_end3_depth", int'(lp_depth), 1);
    idle();
    chk("lp_depth0", int'(lp_depth), 0);

    // overflow
    repeat (5) cyc(0, 0, 0, 1, 16'h0100, 8'd1, 0);
    idle();
    chk("ovf_depth", int'(lp_depth), 4);
    chk("ovf_err", int'(lp_err), 1);

    // underflow after reset
    do_reset();
    chk("rst2_err", int'(lp_err), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("unf_Loop", int'(Loop), 0);
    idle();
    chk("unf_err", int'(lp_err), 1);

    // branch wins over same-cycle ENDLOOP; stack count stays at 2
    do_reset();
    cyc(0, 0, 0, 1, 16'h0005, 8'd2, 0);
    cyc(0, 1, 16'h0040, 0, 0, 0, 1);
    chk("bw_Loop", int'(Loop), 1);
    chk("bw_PC", int'(PC_in), 16'h0040);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("bw_cnt_Loop", int'(Loop), 1);
    chk("bw_cnt_PC", int'(PC_in), 16'h0005);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("bw_pop_Loop", int'(Loop), 0);
    idle();
    chk("bw_depth0", int'(lp_depth), 0);
    chk("bw_err", int'(lp_err), 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLOCK_50); #1;
      reset      = ($urandom_range(0, 199) == 0);
      hz_stall   = ($urandom_range(0, 9) < 3);
      br_valid   = ($urandom_range(0, 9) == 0);
      br_target  = 16'($urandom);
      lp_push    = ($urandom_range(0, 99) < 18);
      lp_body_pc = 16'($urandom);
      lp_count   = 8'($urandom_range(0, 3));
      lp_end     = ($urandom_range(0, 99) < 15);
    end
    do_reset();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
